// File: rtl/cordic.sv
// cordic: rotation-mode CORDIC producing cos/sin of a signed Q1.(DATA_WIDTH-2) angle in radians.
// Build option: define CORDIC_PIPE_EN for a fully unrolled pipeline; otherwise an iterative FSM.
module cordic #(
    parameter int DATA_WIDTH = 8,
    parameter int ITERATIONS = 8,
    parameter int GUARD_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] angle,
    output logic [DATA_WIDTH-1:0] cos_val,
    output logic [DATA_WIDTH-1:0] sin_val
);
    localparam int W    = DATA_WIDTH + GUARD_BITS + 2;
    localparam int FRAC = DATA_WIDTH - 2 + GUARD_BITS;
    localparam int HP   = 20;

    typedef struct packed {
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        logic signed [W-1:0] z;
    } xyz_t;

    // Constants are kept in 2^-20 units and rounded to the internal fraction width.
    function automatic logic signed [W-1:0] hp_round(input longint v);
        longint r;
        r = (v + (64'sd1 <<< (HP - FRAC - 1))) >>> (HP - FRAC);
        return r[W-1:0];
    endfunction

    function automatic longint atan_hp(input int i);
        case (i)
            0:       return 64'sd823550;
            1:       return 64'sd486170;
            2:       return 64'sd256879;
            3:       return 64'sd130396;
            4:       return 64'sd65451;
            5:       return 64'sd32757;
            6:       return 64'sd16383;
            default: return (i < HP) ? (64'sd1 <<< (HP - i)) : 64'sd0;
        endcase
    endfunction

    localparam logic signed [W-1:0] PI      = hp_round(64'sd3294199);
    localparam logic signed [W-1:0] PI_HALF = hp_round(64'sd1647099);
    localparam logic signed [W-1:0] K_INIT  = hp_round(64'sd636751);
    localparam logic signed [W-1:0] HALF    = W'(1) <<< (GUARD_BITS - 1);
    localparam logic signed [W-1:0] MAXV    = W'((1 <<< (DATA_WIDTH - 1)) - 1);
    localparam logic signed [W-1:0] MINV    = -W'(1 <<< (DATA_WIDTH - 1));

    logic signed [W-1:0] atan_rom [ITERATIONS];
    for (genvar g = 0; g < ITERATIONS; g++) begin : g_rom
        assign atan_rom[g] = hp_round(atan_hp(g));
    end

    function automatic logic signed [W-1:0] to_theta(input logic [DATA_WIDTH-1:0] a);
        logic signed [W-1:0] t;
        t = W'($signed(a));
        return t <<< GUARD_BITS;
    endfunction

    function automatic logic needs_fold(input logic signed [W-1:0] t);
        return (t > PI_HALF) || (t < -PI_HALF);
    endfunction

    // Angles outside +-pi/2 are moved by pi; the result is negated at the output.
    function automatic xyz_t init_xyz(input logic signed [W-1:0] t);
        xyz_t s;
        s.x = K_INIT;
        s.y = '0;
        if (t > PI_HALF)
            s.z = t - PI;
        else if (t < -PI_HALF)
            s.z = t + PI;
        else
            s.z = t;
        return s;
    endfunction

    function automatic xyz_t rotate(input xyz_t s, input int i, input logic signed [W-1:0] a);
        xyz_t r;
        if (!s.z[W-1]) begin
            r.x = $signed(s.x) - ($signed(s.y) >>> i);
            r.y = $signed(s.y) + ($signed(s.x) >>> i);
            r.z = $signed(s.z) - a;
        end else begin
            r.x = $signed(s.x) + ($signed(s.y) >>> i);
            r.y = $signed(s.y) - ($signed(s.x) >>> i);
            r.z = $signed(s.z) + a;
        end
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] out_round(input logic signed [W-1:0] v,
                                                        input logic neg);
        logic signed [W-1:0] n;
        logic signed [W-1:0] r;
        n = neg ? -v : v;
        r = (n + HALF) >>> GUARD_BITS;
        if (r > MAXV)
            r = MAXV;
        else if (r < MINV)
            r = MINV;
        return r[DATA_WIDTH-1:0];
    endfunction

`ifdef CORDIC_PIPE_EN
    logic [DATA_WIDTH-1:0] angle_r;
    logic signed [W-1:0]   theta_r;
    xyz_t                  stg [ITERATIONS];
    logic [ITERATIONS-1:0] neg_stg;
    logic [ITERATIONS:0]   vld;

    assign theta_r = to_theta(angle_r);

    // vld marks which stages hold real data since reset; outputs load only from valid data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            angle_r <= '0;
            neg_stg <= '0;
            vld     <= '0;
            cos_val <= '0;
            sin_val <= '0;
            for (int i = 0; i < ITERATIONS; i++) begin
                stg[i] <= '0;
            end
        end else begin
            angle_r    <= angle;
            vld        <= {vld[ITERATIONS-1:0], 1'b1};
            stg[0]     <= rotate(init_xyz(theta_r), 0, atan_rom[0]);
            neg_stg[0] <= needs_fold(theta_r);
            for (int i = 1; i < ITERATIONS; i++) begin
                stg[i]     <= rotate(stg[i-1], i, atan_rom[i]);
                neg_stg[i] <= neg_stg[i-1];
            end
            if (vld[ITERATIONS]) begin
                cos_val <= out_round(stg[ITERATIONS-1].x, neg_stg[ITERATIONS-1]);
                sin_val <= out_round(stg[ITERATIONS-1].y, neg_stg[ITERATIONS-1]);
            end
        end
    end
`else
    localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    typedef enum logic [1:0] {LOAD, ITER, DONE} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] angle_q, angle_nxt;
    xyz_t                  s_q, s_nxt;
    logic                  neg_q, neg_nxt;
    logic [CW-1:0]         cnt_q, cnt_nxt;
    logic [DATA_WIDTH-1:0] cos_nxt, sin_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= LOAD;
            angle_q <= '0;
            s_q     <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            cos_val <= '0;
            sin_val <= '0;
        end else begin
            state   <= state_nxt;
            angle_q <= angle_nxt;
            s_q     <= s_nxt;
            neg_q   <= neg_nxt;
            cnt_q   <= cnt_nxt;
            cos_val <= cos_nxt;
            sin_val <= sin_nxt;
        end
    end

    // A changed input during ITER abandons the run; outputs are only written in DONE.
    always_comb begin
        state_nxt = state;
        angle_nxt = angle_q;
        s_nxt     = s_q;
        neg_nxt   = neg_q;
        cnt_nxt   = cnt_q;
        cos_nxt   = cos_val;
        sin_nxt   = sin_val;
        case (state)
            LOAD: begin
                angle_nxt = angle;
                s_nxt     = init_xyz(to_theta(angle));
                neg_nxt   = needs_fold(to_theta(angle));
                cnt_nxt   = '0;
                state_nxt = ITER;
            end
            ITER: begin
                if (angle != angle_q) begin
                    state_nxt = LOAD;
                end else begin
                    s_nxt   = rotate(s_q, int'(cnt_q), atan_rom[cnt_q]);
                    cnt_nxt = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITERATIONS - 1))
                        state_nxt = DONE;
                end
            end
            DONE: begin
                cos_nxt   = out_round(s_q.x, neg_q);
                sin_nxt   = out_round(s_q.y, neg_q);
                state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end
`endif

endmodule

// File: tb/tb_cordic.sv
// tb_cordic: self-checking bench for cordic; expected cos/sin come from real-valued $cos/$sin.
// Follows the build selected by CORDIC_PIPE_EN.
module tb_cordic;
    localparam int  DW    = 8;
    localparam int  IT    = 8;
    localparam int  GB    = 6;
    localparam int  HOLD  = IT + 5;
    localparam int  MAXO  = (1 << (DW - 1)) - 1;
    localparam int  MINO  = -(1 << (DW - 1));
    localparam real SCALE = 2.0 ** (DW - 2);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] angle;
    logic [DW-1:0] cos_val;
    logic [DW-1:0] sin_val;

    int errors = 0;
    int checks = 0;
    logic [2*DW-1:0] exp_q[$];

    cordic #(.DATA_WIDTH(DW), .ITERATIONS(IT), .GUARD_BITS(GB)) dut (
        .clk     (clk),
        .rst     (rst),
        .angle   (angle),
        .cos_val (cos_val),
        .sin_val (sin_val)
    );

    always #5 clk = ~clk;

    function automatic int ideal(input real v);
        real s;
        int  r;
        s = v * SCALE;
        r = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
        if (r > MAXO) r = MAXO;
        if (r < MINO) r = MINO;
        return r;
    endfunction

    function automatic logic [2*DW-1:0] model(input logic [DW-1:0] a);
        real th;
        int  c;
        int  s;
        th = $itor($signed(a)) / SCALE;
        c  = ideal($cos(th));
        s  = ideal($sin(th));
        return {c[DW-1:0], s[DW-1:0]};
    endfunction

    task automatic drive_angle(input logic [DW-1:0] a);
        angle = a;
        exp_q.push_back(model(a));
    endtask

    task automatic test_reset();
        logic [2*DW-1:0] e;
        int dc;
        int ds;
        rst   = 1'b0;
        angle = 8'h60;
        repeat (3) @(negedge clk);
        checks++;
        if (cos_val !== '0) begin
            errors++;
            $display("FAIL reset_cos got=%h exp=00", cos_val);
        end
        checks++;
        if (sin_val !== '0) begin
            errors++;
            $display("FAIL reset_sin got=%h exp=00", sin_val);
        end
        drive_angle(8'h60);
        rst = 1'b1;
        repeat (IT + 1) @(negedge clk);
        checks++;
        if (cos_val !== '0 || sin_val !== '0) begin
            errors++;
            $display("FAIL reset_early got=%h/%h exp=00/00", cos_val, sin_val);
        end
        @(negedge clk);
        e  = exp_q.pop_front();
        dc = int'($signed(cos_val)) - int'($signed(e[2*DW-1:DW]));
        ds = int'($signed(sin_val)) - int'($signed(e[DW-1:0]));
        checks++;
        if ($isunknown(cos_val) || dc > 1 || dc < -1) begin
            errors++;
            $display("FAIL reset_first_cos got=%0d exp=%0d", $signed(cos_val), $signed(e[2*DW-1:DW]));
        end
        checks++;
        if ($isunknown(sin_val) || ds > 1 || ds < -1) begin
            errors++;
            $display("FAIL reset_first_sin got=%0d exp=%0d", $signed(sin_val), $signed(e[DW-1:0]));
        end
    endtask

    task automatic test_direct();
        logic [DW-1:0]   tbl [6];
        logic [2*DW-1:0] e;
        int dc;
        int ds;
        tbl = '{8'h1C, 8'hE0, 8'h00, 8'h65, 8'h7F, 8'h80};
        for (int i = 0; i < 6; i++) begin
            drive_angle(tbl[i]);
            repeat (HOLD) @(negedge clk);
            e  = exp_q.pop_front();
            dc = int'($signed(cos_val)) - int'($signed(e[2*DW-1:DW]));
            ds = int'($signed(sin_val)) - int'($signed(e[DW-1:0]));
            checks++;
            if ($isunknown(cos_val) || dc > 1 || dc < -1) begin
                errors++;
                $display("FAIL direct_cos angle=%h got=%0d exp=%0d", tbl[i], $signed(cos_val), $signed(e[2*DW-1:DW]));
            end
            checks++;
            if ($isunknown(sin_val) || ds > 1 || ds < -1) begin
                errors++;
                $display("FAIL direct_sin angle=%h got=%0d exp=%0d", tbl[i], $signed(sin_val), $signed(e[DW-1:0]));
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0]   a;
        logic [2*DW-1:0] e;
        int dc;
        int ds;
        for (int i = 0; i < 10; i++) begin
            a = DW'($urandom_range(0, (1 << DW) - 1));
            drive_angle(a);
            repeat (HOLD) @(negedge clk);
            e  = exp_q.pop_front();
            dc = int'($signed(cos_val)) - int'($signed(e[2*DW-1:DW]));
            ds = int'($signed(sin_val)) - int'($signed(e[DW-1:0]));
            checks++;
            if ($isunknown(cos_val) || dc > 1 || dc < -1) begin
                errors++;
                $display("FAIL random_cos angle=%h got=%0d exp=%0d", a, $signed(cos_val), $signed(e[2*DW-1:DW]));
            end
            checks++;
            if ($isunknown(sin_val) || ds > 1 || ds < -1) begin
                errors++;
                $display("FAIL random_sin angle=%h got=%0d exp=%0d", a, $signed(sin_val), $signed(e[DW-1:0]));
            end
        end
    endtask

`ifndef CORDIC_PIPE_EN
    task automatic test_restart();
        logic [2*DW-1:0] eb;
        logic [2*DW-1:0] ec;
        int  dc;
        int  ds;
        bit  seen;
        angle = 8'h00;
        repeat (HOLD) @(negedge clk);
        eb    = model(8'h1C);
        ec    = model(8'hE0);
        angle = 8'h1C;
        seen  = 1'b0;
        for (int k = 0; k < 2 * HOLD && !seen; k++) begin
            @(negedge clk);
            ds = int'($signed(sin_val)) - int'($signed(eb[DW-1:0]));
            if (!$isunknown(sin_val) && ds <= 1 && ds >= -1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL restart_sync got=%0d exp=%0d within %0d clocks", $signed(sin_val), $signed(eb[DW-1:0]), 2 * HOLD);
            return;
        end
        // Outputs just loaded in DONE; the following edge is LOAD, then three ITER edges.
        repeat (4) @(negedge clk);
        angle = 8'hE0;
        for (int k = 1; k <= IT + 2; k++) begin
            @(negedge clk);
            dc = int'($signed(cos_val)) - int'($signed(eb[2*DW-1:DW]));
            ds = int'($signed(sin_val)) - int'($signed(eb[DW-1:0]));
            checks++;
            if ($isunknown({cos_val, sin_val}) || dc > 1 || dc < -1 || ds > 1 || ds < -1) begin
                errors++;
                $display("FAIL restart_hold cycle=%0d got=%0d/%0d exp=%0d/%0d", k, $signed(cos_val), $signed(sin_val),
                         $signed(eb[2*DW-1:DW]), $signed(eb[DW-1:0]));
            end
        end
        @(negedge clk);
        dc = int'($signed(cos_val)) - int'($signed(ec[2*DW-1:DW]));
        ds = int'($signed(sin_val)) - int'($signed(ec[DW-1:0]));
        checks++;
        if ($isunknown({cos_val, sin_val}) || dc > 1 || dc < -1 || ds > 1 || ds < -1) begin
            errors++;
            $display("FAIL restart_new got=%0d/%0d exp=%0d/%0d", $signed(cos_val), $signed(sin_val),
                     $signed(ec[2*DW-1:DW]), $signed(ec[DW-1:0]));
        end
    endtask
`else
    task automatic test_back_to_back();
        logic [DW-1:0]   tbl [3];
        logic [2*DW-1:0] e;
        int dc;
        int ds;
        tbl = '{8'h60, 8'h1C, 8'hE0};
        drive_angle(tbl[0]);
        @(negedge clk);
        drive_angle(tbl[1]);
        @(negedge clk);
        drive_angle(tbl[2]);
        repeat (IT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e  = exp_q.pop_front();
            dc = int'($signed(cos_val)) - int'($signed(e[2*DW-1:DW]));
            ds = int'($signed(sin_val)) - int'($signed(e[DW-1:0]));
            checks++;
            if ($isunknown(cos_val) || dc > 1 || dc < -1) begin
                errors++;
                $display("FAIL b2b_cos idx=%0d got=%0d exp=%0d", i, $signed(cos_val), $signed(e[2*DW-1:DW]));
            end
            checks++;
            if ($isunknown(sin_val) || ds > 1 || ds < -1) begin
                errors++;
                $display("FAIL b2b_sin idx=%0d got=%0d exp=%0d", i, $signed(sin_val), $signed(e[DW-1:0]));
            end
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_async_reset();
        logic [2*DW-1:0] e;
        int dc;
        int ds;
        angle = 8'h1C;
        repeat (HOLD + 3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (cos_val !== '0 || sin_val !== '0) begin
            errors++;
            $display("FAIL async_clear got=%h/%h exp=00/00", cos_val, sin_val);
        end
        @(negedge clk);
        drive_angle(8'hE0);
        rst = 1'b1;
        repeat (IT + 1) @(negedge clk);
        checks++;
        if (cos_val !== '0 || sin_val !== '0) begin
            errors++;
            $display("FAIL async_early got=%h/%h exp=00/00", cos_val, sin_val);
        end
        @(negedge clk);
        e  = exp_q.pop_front();
        dc = int'($signed(cos_val)) - int'($signed(e[2*DW-1:DW]));
        ds = int'($signed(sin_val)) - int'($signed(e[DW-1:0]));
        checks++;
        if ($isunknown(cos_val) || dc > 1 || dc < -1) begin
            errors++;
            $display("FAIL async_recover_cos got=%0d exp=%0d", $signed(cos_val), $signed(e[2*DW-1:DW]));
        end
        checks++;
        if ($isunknown(sin_val) || ds > 1 || ds < -1) begin
            errors++;
            $display("FAIL async_recover_sin got=%0d exp=%0d", $signed(sin_val), $signed(e[DW-1:0]));
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_random();
`ifndef CORDIC_PIPE_EN
        test_restart();
`else
        test_back_to_back();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
